// File: rtl/add_shift_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// mult_types
//   Shared types and constants for the sequential add-shift multiplier.
//   WIDTH      : operand width in bits (product is 2*WIDTH bits)
//   CNT_W      : width of the iteration counter, wide enough to hold WIDTH
//   operand_t  : one operand (multiplicand or multiplier)
//   result_t   : full-width product
//   acc_t      : accumulator with one extra carry bit
//   mult_state_e : control FSM states
// -----------------------------------------------------------------------------
package mult_types;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef logic [WIDTH-1:0]   operand_t;
    typedef logic [2*WIDTH-1:0] result_t;
    typedef logic [WIDTH:0]     acc_t;
    typedef logic [CNT_W-1:0]   count_t;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        SHIFT,
        DONE
    } mult_state_e;

endpackage : mult_types

// File: rtl/add_shift_multiplier.sv
// -----------------------------------------------------------------------------
// add_shift_multiplier
//   Sequential unsigned multiplier. One ADD and one SHIFT step per multiplier
//   bit, so every operation takes exactly 2*WIDTH cycles from accepted start
//   to done_o.
//
// Ports
//   clk_i          : clock, rising edge active
//   reset_n_i      : asynchronous active-low reset
//   start_i        : request a multiply; accepted only while ready_o=1
//   multiplicand_i : operand M, sampled on accepted start
//   multiplier_i   : operand Q, sampled on accepted start
//   ready_o        : block can accept start_i (IDLE or DONE)
//   product_o      : result, valid while done_o=1, otherwise 0
//   done_o         : product_o holds the result of the last accepted operation
// -----------------------------------------------------------------------------
module add_shift_multiplier
    import mult_types::*;
(
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 ready_o,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 done_o
);

    mult_state_e r_state;
    mult_state_e w_state_next;

    acc_t     r_acc;   // A: partial product high half plus carry
    operand_t r_q;     // Q: multiplier, low half of product shifts in here
    operand_t r_m;     // M: multiplicand
    count_t   r_cnt;   // completed SHIFT steps

    logic     w_accept;
    logic     w_last;
    count_t   w_cnt_inc;

    // Start is only honoured while idle or holding a result; ADD/SHIFT ignore it.
    assign w_accept  = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_last    = (w_cnt_inc == count_t'(WIDTH));

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: the default assignment first keeps this purely combinational;
    // any path that leaves w_state_next unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = ADD;
            ADD:     w_state_next = SHIFT;
            SHIFT:   w_state_next = w_last ? DONE : ADD;
            DONE:    if (w_accept) w_state_next = ADD;
            default: w_state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Decoded from state and registers only, so no input reaches an output
    // combinationally and a reset immediately forces product_o to zero.
    always_comb begin
        ready_o   = 1'b0;
        done_o    = 1'b0;
        product_o = '0;
        case (r_state)
            IDLE: ready_o = 1'b1;
            DONE: begin
                ready_o   = 1'b1;
                done_o    = 1'b1;
                product_o = {r_acc[WIDTH-1:0], r_q};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_acc <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_acc <= '0;
                        r_q   <= multiplier_i;
                        r_m   <= multiplicand_i;
                        r_cnt <= '0;
                    end
                end
                ADD: begin
                    // Carry lands in r_acc[WIDTH] and is shifted down next step.
                    if (r_q[0]) begin
                        r_acc <= r_acc + {1'b0, r_m};
                    end
                end
                SHIFT: begin
                    r_acc <= r_acc >> 1;
                    r_q   <= {r_acc[0], r_q[WIDTH-1:1]};
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule : add_shift_multiplier
